// File: rtl/dfe_coeff_loader.sv
// Word-serial coefficient loader with gap-deferred commit for the frac-decimator / IIR datapath.
// Optional readback port: define DFE_CFG_RDBK_EN to add rd_addr/rd_data.
module dfe_coeff_loader #(
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int GAP_CYCLES  = 4,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [ADDR_WIDTH-1:0]               cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0]       cfg_data,
  input  logic                                cfg_commit,
  input  logic                                dp_valid_in,
  output logic                                cfg_busy,
  output logic                                cfg_done,
  output logic                                cfg_err,
  output logic [N_TAP-1:0][COEFF_WIDTH-1:0]   frac_dec_coeff_out,
  output logic                                frac_dec_coeff_wr_en,
  output logic [2:0][COEFF_WIDTH-1:0]         iir_num_2_4_out,
  output logic [1:0][COEFF_WIDTH-1:0]         iir_den_2_4_out,
  output logic [2:0][COEFF_WIDTH-1:0]         iir_num_2_out,
  output logic [1:0][COEFF_WIDTH-1:0]         iir_den_2_out,
  output logic [2:0][COEFF_WIDTH-1:0]         iir_num_1_out,
  output logic [1:0][COEFF_WIDTH-1:0]         iir_den_1_out,
  output logic                                iir_num_2_4_wr_en,
  output logic                                iir_den_2_4_wr_en,
  output logic                                iir_num_2_wr_en,
  output logic                                iir_den_2_wr_en,
  output logic                                iir_num_1_wr_en,
  output logic                                iir_den_1_wr_en,
`ifdef DFE_CFG_RDBK_EN
  output logic [1:0]                          dbg_state_o,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  output logic [COEFF_WIDTH-1:0]              rd_data
`else
  output logic [1:0]                          dbg_state_o
`endif
);

  localparam int N_SH = N_TAP + 15;
  localparam int GW   = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

  localparam logic [ADDR_WIDTH-1:0] A_N24  = ADDR_WIDTH'(N_TAP);
  localparam logic [ADDR_WIDTH-1:0] A_D24  = ADDR_WIDTH'(N_TAP + 3);
  localparam logic [ADDR_WIDTH-1:0] A_N2   = ADDR_WIDTH'(N_TAP + 5);
  localparam logic [ADDR_WIDTH-1:0] A_D2   = ADDR_WIDTH'(N_TAP + 8);
  localparam logic [ADDR_WIDTH-1:0] A_N1   = ADDR_WIDTH'(N_TAP + 10);
  localparam logic [ADDR_WIDTH-1:0] A_D1   = ADDR_WIDTH'(N_TAP + 13);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(N_TAP + 14);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, APPLY, DONE} state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 gap_q, gap_d;
  logic [6:0]                    dirty_q, dirty_d;
  logic [6:0]                    wr_en_q, wr_en_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic signed [COEFF_WIDTH-1:0] shadow_q [N_SH];
  logic signed [COEFF_WIDTH-1:0] shadow_d [N_SH];
  logic [6:0]                    bank_sel;
  logic                          addr_ok;
  logic                          wr_take;
  logic                          wr_accept;

  // Bank bit order: 0=F, 1=N24, 2=D24, 3=N2, 4=D2, 5=N1, 6=D1 (same order as wr_en_q).
  always_comb begin
    bank_sel = '0;
    if (cfg_addr < A_N24)       bank_sel[0] = 1'b1;
    else if (cfg_addr < A_D24)  bank_sel[1] = 1'b1;
    else if (cfg_addr < A_N2)   bank_sel[2] = 1'b1;
    else if (cfg_addr < A_D2)   bank_sel[3] = 1'b1;
    else if (cfg_addr < A_N1)   bank_sel[4] = 1'b1;
    else if (cfg_addr < A_D1)   bank_sel[5] = 1'b1;
    else if (cfg_addr <= A_LAST) bank_sel[6] = 1'b1;
  end

  assign addr_ok   = |bank_sel;
  assign cfg_ready = (state_q == IDLE);
  assign cfg_busy  = (state_q == WAIT_GAP) || (state_q == APPLY);
  assign wr_take   = cfg_valid && cfg_ready;
  assign wr_accept = wr_take && addr_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cfg_commit) state_d = WAIT_GAP;
      WAIT_GAP: if ((gap_q == GAP_MAX) && !dp_valid_in) state_d = APPLY;
      APPLY:    state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    gap_d = gap_q;
    if (dp_valid_in)          gap_d = '0;
    else if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
  end

  // Writes are only taken in IDLE, so dirty never changes while a commit is in flight.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == APPLY) dirty_d = '0;
    else if (wr_accept)   dirty_d = dirty_q | bank_sel;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (wr_accept) shadow_d[cfg_addr] = cfg_data;
  end

  assign wr_en_d = (state_d == APPLY) ? dirty_q : '0;
  assign done_d  = (state_d == DONE);
  assign err_d   = wr_take && !addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      dirty_q <= '0;
      wr_en_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_SH; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      dirty_q  <= dirty_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  assign cfg_done             = done_q;
  assign cfg_err              = err_q;
  assign dbg_state_o          = state_q;
  assign frac_dec_coeff_wr_en = wr_en_q[0];
  assign iir_num_2_4_wr_en    = wr_en_q[1];
  assign iir_den_2_4_wr_en    = wr_en_q[2];
  assign iir_num_2_wr_en      = wr_en_q[3];
  assign iir_den_2_wr_en      = wr_en_q[4];
  assign iir_num_1_wr_en      = wr_en_q[5];
  assign iir_den_1_wr_en      = wr_en_q[6];

  for (genvar i = 0; i < N_TAP; i++) begin : g_frac
    assign frac_dec_coeff_out[i] = shadow_q[i];
  end

  for (genvar j = 0; j < 3; j++) begin : g_num
    assign iir_num_2_4_out[j] = shadow_q[N_TAP + j];
    assign iir_num_2_out[j]   = shadow_q[N_TAP + 5 + j];
    assign iir_num_1_out[j]   = shadow_q[N_TAP + 10 + j];
  end

  for (genvar j = 0; j < 2; j++) begin : g_den
    assign iir_den_2_4_out[j] = shadow_q[N_TAP + 3 + j];
    assign iir_den_2_out[j]   = shadow_q[N_TAP + 8 + j];
    assign iir_den_1_out[j]   = shadow_q[N_TAP + 13 + j];
  end

`ifdef DFE_CFG_RDBK_EN
  assign rd_data = (rd_addr <= A_LAST) ? shadow_q[rd_addr] : '0;
`endif

endmodule

// File: tb/tb_dfe_coeff_loader.sv
// Bench for dfe_coeff_loader: timeline model of the commit protocol plus directed literal checks.
// Readback checks are compiled in when DFE_CFG_RDBK_EN is defined.
module tb_dfe_coeff_loader;
  localparam int CW    = 20;
  localparam int N_TAP = 72;
  localparam int GAP   = 4;
  localparam int AW    = 7;
  localparam int N_SH  = N_TAP + 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0, cfg_commit = 1'b0, dp_valid_in = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [N_TAP-1:0][CW-1:0] frac_out;
  logic [2:0][CW-1:0] n24, n2, n1;
  logic [1:0][CW-1:0] d24, d2, d1;
  logic frac_wr, n24_wr, d24_wr, n2_wr, d2_wr, n1_wr, d1_wr;
  logic [1:0] dbg_state;
`ifdef DFE_CFG_RDBK_EN
  logic [AW-1:0] rd_addr = '0;
  logic [CW-1:0] rd_data;
`endif

  dfe_coeff_loader #(.COEFF_WIDTH(CW), .N_TAP(N_TAP), .GAP_CYCLES(GAP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .dp_valid_in(dp_valid_in), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .frac_dec_coeff_out(frac_out), .frac_dec_coeff_wr_en(frac_wr),
    .iir_num_2_4_out(n24), .iir_den_2_4_out(d24), .iir_num_2_out(n2),
    .iir_den_2_out(d2), .iir_num_1_out(n1), .iir_den_1_out(d1),
    .iir_num_2_4_wr_en(n24_wr), .iir_den_2_4_wr_en(d24_wr), .iir_num_2_wr_en(n2_wr),
    .iir_den_2_wr_en(d2_wr), .iir_num_1_wr_en(n1_wr), .iir_den_1_wr_en(d1_wr),
`ifdef DFE_CFG_RDBK_EN
    .dbg_state_o(dbg_state), .rd_addr(rd_addr), .rd_data(rd_data)
`else
    .dbg_state_o(dbg_state)
`endif
  );

  logic [6:0] wr_vec;
  assign wr_vec = {d1_wr, n1_wr, d2_wr, n2_wr, d24_wr, n24_wr, frac_wr};

  logic [CW-1:0] dut_sh [N_SH];
  always_comb begin
    for (int i = 0; i < N_TAP; i++) dut_sh[i] = frac_out[i];
    for (int j = 0; j < 3; j++) begin
      dut_sh[N_TAP + j]      = n24[j];
      dut_sh[N_TAP + 5 + j]  = n2[j];
      dut_sh[N_TAP + 10 + j] = n1[j];
    end
    for (int j = 0; j < 2; j++) begin
      dut_sh[N_TAP + 3 + j]  = d24[j];
      dut_sh[N_TAP + 8 + j]  = d2[j];
      dut_sh[N_TAP + 13 + j] = d1[j];
    end
  end

  int n_pass = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  // Model: commit timeline from idle-run length, plus an address-indexed shadow image.
  logic [CW-1:0] m_sh [N_SH];
  logic [6:0] m_dirty, m_wr, exp_wr;
  bit m_waiting, exp_ready, exp_busy, exp_done, exp_err, m_bad;
  int idle_run, apply_cyc, cyc = 0, m_bank;

  function automatic int bank_of(input int a);
    if (a < N_TAP) return 0;
    if (a >= N_SH) return -1;
    case (a - N_TAP)
      0, 1, 2:    return 1;
      3, 4:       return 2;
      5, 6, 7:    return 3;
      8, 9:       return 4;
      10, 11, 12: return 5;
      default:    return 6;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SH; i++) m_sh[i] = '0;
      m_dirty = '0; m_wr = '0; m_waiting = 1'b0; idle_run = 0; apply_cyc = -100;
      exp_ready = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_wr = '0;
    end else begin
      m_bad = 1'b0;
      if (m_waiting && idle_run >= GAP && !dp_valid_in) begin
        m_waiting = 1'b0;
        apply_cyc = cyc + 1;
        m_wr = m_dirty;
        m_dirty = '0;
      end
      idle_run = dp_valid_in ? 0 : idle_run + 1;
      if (exp_ready && cfg_valid) begin
        m_bank = bank_of(int'(cfg_addr));
        if (m_bank < 0) m_bad = 1'b1;
        else begin
          m_sh[cfg_addr] = cfg_data;
          m_dirty[m_bank] = 1'b1;
        end
      end
      if (exp_ready && cfg_commit) m_waiting = 1'b1;
      cyc++;
      exp_wr    = (cyc == apply_cyc) ? m_wr : '0;
      exp_done  = (cyc == apply_cyc + 1);
      exp_busy  = m_waiting || (cyc == apply_cyc);
      exp_ready = !exp_busy && !exp_done;
      exp_err   = m_bad;
    end
  end

  // Scoreboard compare on the falling edge.
  logic [10:0] got_v, exp_v;
  int bad_i;
  always @(negedge clk) begin
    if (chk_en) begin
      got_v = {cfg_ready, cfg_busy, cfg_done, cfg_err, wr_vec};
      exp_v = {exp_ready, exp_busy, exp_done, exp_err, exp_wr};
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL ctrl t=%0t got=%b exp=%b (rdy,busy,done,err,wr[6:0]) state=%0d", $time, got_v, exp_v, dbg_state);
      bad_i = -1;
      for (int i = N_SH - 1; i >= 0; i--) if (dut_sh[i] !== m_sh[i]) bad_i = i;
      n_checks++;
      if (bad_i < 0) n_pass++;
      else $display("FAIL shadow t=%0t idx=%0d got=%h exp=%h", $time, bad_i, dut_sh[bad_i], m_sh[bad_i]);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    cfg_valid = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_done(output logic [6:0] mask);
    mask = '0;
    for (int i = 0; i < 60; i++) begin
      mask |= wr_vec;
      if (cfg_done) return;
      tick();
    end
    lit("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [6:0] mask;
  initial begin
    // reset
    tick(); chk_en = 1'b1; tick();
    lit("rst_ready", cfg_ready, 1); lit("rst_busy", cfg_busy, 0);
    lit("rst_done", cfg_done, 0); lit("rst_wr", wr_vec, 0); lit("rst_tap0", frac_out[0], 0);
    rst_n = 1'b1;
    repeat (6) tick();

    // 1: two frac taps, commit with idle datapath
    wr(0, 20'h12345);
    wr(71, 20'hFFFFF);
    do_commit();
    lit("t1_wr_t1", wr_vec, 0);
    tick();
    lit("t1_frac_wr", frac_wr, 1); lit("t1_iir_wr", wr_vec[6:1], 0);
    lit("t1_tap0", frac_out[0], 32'h12345); lit("t1_tap71", frac_out[71], 32'hFFFFF);
    tick();
    lit("t1_done", cfg_done, 1); lit("t1_wr_off", wr_vec, 0);
    tick();
    lit("t1_ready", cfg_ready, 1);

    // 2: commit while the datapath toggles
    wr(N_TAP + 13, 20'd100);
    for (int i = 0; i < 20; i++) begin
      dp_valid_in = (i % 2 == 0);
      if (i == 0) cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
    end
    dp_valid_in = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      lit("t2_quiet", d1_wr, 0);
      tick();
    end
    lit("t2_den1_wr", d1_wr, 1); lit("t2_den1_val", d1[0], 100);
    tick(); tick();

    // 3: bad address
    wr(90, 20'h00ABC);
    lit("t3_err", cfg_err, 1);
    tick();
    lit("t3_err_off", cfg_err, 0);
    do_commit();
    wait_done(mask);
    lit("t3_no_wr", mask, 0);
    tick();

    // 4: write held during WAIT_GAP
    dp_valid_in = 1'b1;
    do_commit();
    cfg_valid = 1'b1; cfg_addr = AW'(N_TAP); cfg_data = 20'd77;
    for (int k = 0; k < 5; k++) begin
      lit("t4_stall", cfg_ready, 0);
      tick();
    end
    dp_valid_in = 1'b0;
    wait_done(mask);
    lit("t4_first_mask", mask, 0); lit("t4_done_rdy", cfg_ready, 0);
    tick();
    lit("t4_idle_rdy", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    lit("t4_n24_val", n24[0], 77);
    do_commit();
    wait_done(mask);
    lit("t4_second_mask", mask, 32'b0000010);
    tick();

    // 5: write and commit in the same cycle
    cfg_valid = 1'b1; cfg_addr = AW'(N_TAP + 5); cfg_data = 20'hFFFFB; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    lit("t5_wr_t1", n2_wr, 0);
    tick();
    lit("t5_num2_wr", n2_wr, 1); lit("t5_num2_val", n2[0], 32'hFFFFB);
    tick();
    lit("t5_done", cfg_done, 1);
    tick();

    // 7: several banks in one commit
    wr(N_TAP + 3, 20'd11);
    wr(N_TAP + 9, 20'hFFFFE);
    wr(N_TAP + 12, 20'd33);
    wr(5, 20'd1234);
    do_commit();
    wait_done(mask);
    lit("t7_mask", mask, 32'b0110101);
    tick();

    // 6: reset during WAIT_GAP
    wr(1, 20'd5);
    dp_valid_in = 1'b1;
    do_commit();
    repeat (3) tick();
    lit("t6_busy_pre", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    lit("t6_busy", cfg_busy, 0); lit("t6_wr", wr_vec, 0);
    lit("t6_tap1", frac_out[1], 0); lit("t6_tap5", frac_out[5], 0); lit("t6_num2", n2[0], 0);
`ifdef DFE_CFG_RDBK_EN
    for (int a = 0; a < 128; a++) begin
      rd_addr = AW'(a);
      #1;
      lit("t6_rdbk", rd_data, 0);
    end
`endif
    tick(); tick();
    rst_n = 1'b1;
    dp_valid_in = 1'b0;
    mask = '0;
    for (int k = 0; k < 10; k++) begin
      mask |= wr_vec;
      tick();
    end
    lit("t6_no_strobe", mask, 0);

`ifdef DFE_CFG_RDBK_EN
    wr(N_TAP + 14, 20'd42);
    rd_addr = AW'(N_TAP + 14);
    #1;
    lit("rdbk_val", rd_data, 42);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
